axi4_wr_route_checker: RTL and testbench
========================================

Name: axi4_wr_route_checker

Overview:
- Parametrised write-path router: one AXI4 master port to NUM_SLAVES slave ports, with per-slave address windows.
- Every AW is checked before forwarding: address decode, per-slave AxPROT policy, INCR 4KB-crossing and oversize AxSIZE.
- Failing bursts never reach a slave. An internal error responder drains their W beats and returns DECERR/SLVERR on B.
- B returns from all slaves and the responder are merged by a round-robin arbiter. Sits between an interconnect master port and its slave fabric.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width (power of 2, >=8)
- ID_WIDTH, 4, AXI ID width
- NUM_SLAVES, 3, slave ports (1..8)
- SLV_BASE, NUM_SLAVES*ADDR_WIDTH flat, window base per slave (slave i at [i*ADDR_WIDTH +: ADDR_WIDTH])
- SLV_MASK, NUM_SLAVES*ADDR_WIDTH flat, window mask per slave
- SLV_SECURE_ONLY, NUM_SLAVES bits, bit i set: slave i rejects AxPROT[1]=1
- SLV_PRIV_ONLY, NUM_SLAVES bits, bit i set: slave i rejects AxPROT[0]=0
- ROUTE_DEPTH, 8, route FIFO entries (power of 2, >=2)

Ports:
- aclk  in  1  clock
- areset  in  1  reset; synchronous, active-high
- m_awid/m_awaddr/m_awlen/m_awsize/m_awburst/m_awprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/3  master AW payload
- m_awvalid  in  1  AW valid
- m_awready  out  1  AW ready
- m_wdata/m_wstrb/m_wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  master W payload
- m_wvalid  in  1  W valid
- m_wready  out  1  W ready
- m_bid/m_bresp  out  ID_WIDTH/2  B payload
- m_bvalid  out  1  B valid
- m_bready  in  1  B ready
- s_aw  out  ID_WIDTH+ADDR_WIDTH+16  {awid,awaddr,awlen,awsize,awburst,awprot}, broadcast to all slaves
- s_awvalid  out  NUM_SLAVES  per-slave AW valid
- s_awready  in  NUM_SLAVES  per-slave AW ready
- s_w  out  DATA_WIDTH+DATA_WIDTH/8+1  {wdata,wstrb,wlast}, broadcast to all slaves
- s_wvalid  out  NUM_SLAVES  per-slave W valid
- s_wready  in  NUM_SLAVES  per-slave W ready
- s_bid  in  NUM_SLAVES*ID_WIDTH  flat slave B IDs
- s_bresp  in  NUM_SLAVES*2  flat slave B responses
- s_bvalid  in  NUM_SLAVES  per-slave B valid
- s_bready  out  NUM_SLAVES  per-slave B ready
- decerr_cnt  out  16  saturating DECERR count
- slverr_cnt  out  16  saturating SLVERR count
- wlast_err  out  1  sticky: WLAST position mismatch seen on a drained burst

Behaviour:
- Reset: FIFO empty; FSM IDLE; RR pointer 0; grant unlocked; counters 0; wlast_err 0. All valid/ready outputs deasserted (combinational outputs gated).
- Decode (combinational): slave i hits when (m_awaddr & MASK_i) == BASE_i. Lowest hitting index wins. No hit -> DECERR (2'b11).
- Checks on a hit, any failing -> SLVERR (2'b10):
  - Security: SECURE_ONLY[i] and awprot[1]=1.
  - Privilege: PRIV_ONLY[i] and awprot[0]=0.
  - Oversize: awsize > log2(DATA_WIDTH/8).
  - 4KB crossing, INCR only: end = addr + ((len+1)<<size) - 1, computed at ADDR_WIDTH+1 bits. Crossing when addr[ADDR_WIDTH-1:12] differs from end[ADDR_WIDTH-1:12], or end bit ADDR_WIDTH is set (address-space wrap). FIXED and WRAP are exempt.
- AW:
  - FIFO full -> m_awready=0, all s_awvalid=0.
  - Good burst: s_awvalid[sel]=m_awvalid; m_awready=s_awready[sel].
  - Error burst: m_awready=1 and no s_awvalid.
  - s_aw always carries the m_aw fields. Zero added latency.
- Push: on m_awvalid & m_awready, push {sel, err, resp, id, len}.
- W (steered by FIFO head):
  - Empty FIFO -> m_wready=0.
  - Good head: s_wvalid[sel]=m_wvalid; m_wready=s_wready[sel]. Pop on the beat with wlast. The beat count is ignored here; the slave owns protocol checks.
  - Error head: handled by the FSM.
- Error FSM:
  - IDLE -> DRAIN when the head is an error entry. Beat counter loads 0.
  - DRAIN: m_wready=1. Count accepted beats. Beat == len, or any beat with wlast -> RESP. If wlast does not coincide with beat == len, set wlast_err.
  - RESP: present {id, resp} to the B arbiter. On handshake: pop FIFO, increment the matching counter (saturate at 16'hFFFF), -> IDLE.
  - W to later bursts stalls until the FSM returns to IDLE.
- Simultaneous push and pop with the FIFO full: legal only when a pop occurs; AW readiness uses the current-cycle full flag. Pointers wrap modulo ROUTE_DEPTH. Full and empty are distinguished by an extra pointer bit.
- B arbiter:
  - Sources are slaves 0..NUM_SLAVES-1 plus the responder at index NUM_SLAVES.
  - While unlocked, pick the first valid source at or after the RR pointer and lock it.
  - m_b* and s_bready come combinationally from the locked source.
  - On m_bvalid & m_bready: unlock and set pointer = grant+1 mod (NUM_SLAVES+1).
  - The grant is never switched while m_bvalid=1 without bready.
- Reset mid-burst: everything returns to reset values on the next edge. In-flight bursts are abandoned.

Test Plan:
1. NUM_SLAVES=3, BASE1=0x1000_0000, MASK=0xF000_0000, AW addr 0x1000_0040 len=3 INCR size=3 prot=0 -> s_awvalid=3'b010, 4 W beats on s_wvalid[1], slave B OKAY id=5 forwarded with m_bid=5.
2. AW addr 0x7000_0000 (no hit) id=2 len=1 -> no s_awvalid; 2 beats drained with m_wready=1; m_bresp=2'b11 m_bid=2; decerr_cnt=1.
3. INCR addr 0x1000_0FF8 len=1 size=3 -> 4KB crossing; SLVERR, slverr_cnt=1. Same request as FIXED -> forwarded.
4. SECURE_ONLY[0]=1, prot=3'b010 to slave 0 -> SLVERR. prot=3'b000 -> forwarded.
5. ROUTE_DEPTH=2, slaves hold s_wready=0, 3 back-to-back AWs -> third stalls (m_awready=0) until the first wlast is popped.
6. Slaves 0, 1 and the responder all present B in the same cycle, with continuous bready -> granted 0, 1, responder in order, one per cycle. With bready=0 held, the grant and m_bid stay stable.

Source files
------------

// File: rtl/axi4_wr_route_checker.sv
// AXI4 write-path router with per-burst policy checks. Bursts that fail decode,
// protection, oversize or 4KB checks are kept away from the slaves: an internal
// responder drains their W beats and answers on B with DECERR/SLVERR.
module axi4_wr_route_checker #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {3{32'hF000_0000}},
  parameter logic [NUM_SLAVES-1:0] SLV_SECURE_ONLY = '0,
  parameter logic [NUM_SLAVES-1:0] SLV_PRIV_ONLY   = '0,
  parameter int unsigned ROUTE_DEPTH = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ID_WIDTH-1:0]              m_awid,
  input  logic [ADDR_WIDTH-1:0]            m_awaddr,
  input  logic [7:0]                       m_awlen,
  input  logic [2:0]                       m_awsize,
  input  logic [1:0]                       m_awburst,
  input  logic [2:0]                       m_awprot,
  input  logic                             m_awvalid,
  output logic                             m_awready,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic [DATA_WIDTH/8-1:0]          m_wstrb,
  input  logic                             m_wlast,
  input  logic                             m_wvalid,
  output logic                             m_wready,
  output logic [ID_WIDTH-1:0]              m_bid,
  output logic [1:0]                       m_bresp,
  output logic                             m_bvalid,
  input  logic                             m_bready,
  output logic [ID_WIDTH+ADDR_WIDTH+15:0]  s_aw,
  output logic [NUM_SLAVES-1:0]            s_awvalid,
  input  logic [NUM_SLAVES-1:0]            s_awready,
  output logic [DATA_WIDTH+DATA_WIDTH/8:0] s_w,
  output logic [NUM_SLAVES-1:0]            s_wvalid,
  input  logic [NUM_SLAVES-1:0]            s_wready,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_bid,
  input  logic [NUM_SLAVES*2-1:0]          s_bresp,
  input  logic [NUM_SLAVES-1:0]            s_bvalid,
  output logic [NUM_SLAVES-1:0]            s_bready,
  output logic [15:0]                      decerr_cnt,
  output logic [15:0]                      slverr_cnt,
  output logic                             wlast_err
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned NSRC  = NUM_SLAVES + 1;
  localparam int unsigned SRC_W = $clog2(NSRC);
  localparam int unsigned IDX_W = $clog2(ROUTE_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [2:0]  SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {StIdle, StDrain, StResp} state_e;

  // AW decode and checks
  logic                  w_hit;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_policy_fail;
  logic [ADDR_WIDTH:0]   w_bytes;
  logic [ADDR_WIDTH:0]   w_end;
  logic                  w_cross;
  logic                  w_oversize;
  logic                  w_err;
  logic [1:0]            w_resp;

  // Route FIFO
  logic [SEL_W-1:0]      r_f_sel  [ROUTE_DEPTH];
  logic                  r_f_err  [ROUTE_DEPTH];
  logic [1:0]            r_f_resp [ROUTE_DEPTH];
  logic [ID_WIDTH-1:0]   r_f_id   [ROUTE_DEPTH];
  logic [7:0]            r_f_len  [ROUTE_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic                  w_empty, w_full, w_push, w_pop, w_pop_w;
  logic [SEL_W-1:0]      w_h_sel;
  logic                  w_h_err;
  logic [1:0]            w_h_resp;
  logic [ID_WIDTH-1:0]   w_h_id;
  logic [7:0]            w_h_len;

  // Error responder FSM
  state_e                r_state, w_state_nxt;
  logic [7:0]            r_beat, w_beat_nxt;
  logic                  w_set_wlast_err;
  logic                  w_rsp_valid, w_rsp_hs;

  // B arbiter
  logic                  r_locked;
  logic [SRC_W-1:0]      r_grant, r_rr, w_grant;
  logic                  w_b_hs;

  assign s_aw = {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awprot};
  assign s_w  = {m_wdata, m_wstrb, m_wlast};

  // Address decode: descending scan so the lowest hitting slave wins
  always_comb begin
    w_hit         = 1'b0;
    w_sel         = '0;
    w_policy_fail = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m_awaddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit         = 1'b1;
        w_sel         = SEL_W'(i);
        w_policy_fail = (SLV_SECURE_ONLY[i] & m_awprot[1]) | (SLV_PRIV_ONLY[i] & ~m_awprot[0]);
      end
    end
  end

  // End address carries one extra bit so a wrap past the top of memory counts as a crossing
  assign w_bytes    = ({{(ADDR_WIDTH-7){1'b0}}, m_awlen} + (ADDR_WIDTH+1)'(1)) << m_awsize;
  assign w_end      = {1'b0, m_awaddr} + w_bytes - (ADDR_WIDTH+1)'(1);
  assign w_cross    = (m_awburst == 2'b01) && ((w_end >> 12) != ({1'b0, m_awaddr} >> 12));
  assign w_oversize = m_awsize > SIZE_MAX;
  assign w_err      = !w_hit || w_policy_fail || w_oversize || w_cross;
  assign w_resp     = w_hit ? 2'b10 : 2'b11;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign w_h_sel  = r_f_sel[r_rptr[IDX_W-1:0]];
  assign w_h_err  = r_f_err[r_rptr[IDX_W-1:0]];
  assign w_h_resp = r_f_resp[r_rptr[IDX_W-1:0]];
  assign w_h_id   = r_f_id[r_rptr[IDX_W-1:0]];
  assign w_h_len  = r_f_len[r_rptr[IDX_W-1:0]];

  // AW steering: error bursts are swallowed here, good bursts pass through unregistered
  always_comb begin
    s_awvalid = '0;
    m_awready = 1'b0;
    if (!areset && !w_full) begin
      if (w_err) begin
        m_awready = 1'b1;
      end else begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
          if (w_sel == SEL_W'(i)) begin
            s_awvalid[i] = m_awvalid;
            m_awready    = s_awready[i];
          end
        end
      end
    end
  end

  assign w_push = m_awvalid && m_awready;
  assign w_pop  = w_pop_w || w_rsp_hs;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_f_sel[r_wptr[IDX_W-1:0]]  <= w_sel;
      r_f_err[r_wptr[IDX_W-1:0]]  <= w_err;
      r_f_resp[r_wptr[IDX_W-1:0]] <= w_resp;
      r_f_id[r_wptr[IDX_W-1:0]]   <= m_awid;
      r_f_len[r_wptr[IDX_W-1:0]]  <= m_awlen;
    end
  end

  // FIFO pointers
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // W steering by FIFO head plus error-responder next state
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_set_wlast_err = 1'b0;
    m_wready        = 1'b0;
    s_wvalid        = '0;
    w_pop_w         = 1'b0;
    if (!areset) begin
      case (r_state)
        StIdle: begin
          if (!w_empty) begin
            if (w_h_err) begin
              w_state_nxt = StDrain;
              w_beat_nxt  = '0;
            end else begin
              for (int i = 0; i < int'(NUM_SLAVES); i++) begin
                if (w_h_sel == SEL_W'(i)) begin
                  s_wvalid[i] = m_wvalid;
                  m_wready    = s_wready[i];
                end
              end
              w_pop_w = m_wvalid && m_wready && m_wlast;
            end
          end
        end
        StDrain: begin
          m_wready = 1'b1;
          if (m_wvalid) begin
            if ((r_beat == w_h_len) || m_wlast) begin
              w_state_nxt     = StResp;
              w_set_wlast_err = m_wlast != (r_beat == w_h_len);
            end else begin
              w_beat_nxt = r_beat + 8'd1;
            end
          end
        end
        StResp: begin
          if (w_rsp_hs) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Responder state, beat counter, error counters and sticky WLAST flag
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= StIdle;
      r_beat     <= '0;
      decerr_cnt <= '0;
      slverr_cnt <= '0;
      wlast_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_set_wlast_err) wlast_err <= 1'b1;
      if (w_rsp_hs) begin
        if (w_h_resp == 2'b11) begin
          if (decerr_cnt != 16'hFFFF) decerr_cnt <= decerr_cnt + 16'd1;
        end else begin
          if (slverr_cnt != 16'hFFFF) slverr_cnt <= slverr_cnt + 16'd1;
        end
      end
    end
  end

  assign w_rsp_valid = (r_state == StResp) && !areset;

  // B arbiter: unlocked grant is combinational, held once B stalls
  always_comb begin
    int idx;
    idx      = 0;
    w_grant  = r_grant;
    if (!r_locked) begin
      for (int k = int'(NSRC) - 1; k >= 0; k--) begin
        idx = int'(r_rr) + k;
        if (idx >= int'(NSRC)) idx = idx - int'(NSRC);
        if ((idx == int'(NUM_SLAVES)) ? w_rsp_valid : s_bvalid[idx % int'(NUM_SLAVES)]) begin
          w_grant = SRC_W'(idx);
        end
      end
    end
    m_bvalid = 1'b0;
    m_bid    = '0;
    m_bresp  = '0;
    s_bready = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (w_grant == SRC_W'(i)) begin
        m_bvalid    = s_bvalid[i];
        m_bid       = s_bid[i*ID_WIDTH +: ID_WIDTH];
        m_bresp     = s_bresp[i*2 +: 2];
        s_bready[i] = m_bready;
      end
    end
    if (w_grant == SRC_W'(NUM_SLAVES)) begin
      m_bvalid = w_rsp_valid;
      m_bid    = w_h_id;
      m_bresp  = w_h_resp;
    end
    if (areset) begin
      m_bvalid = 1'b0;
      s_bready = '0;
    end
  end

  assign w_b_hs   = m_bvalid && m_bready;
  assign w_rsp_hs = w_b_hs && (w_grant == SRC_W'(NUM_SLAVES));

  // Arbiter lock and round-robin pointer
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_locked <= 1'b0;
      r_grant  <= '0;
      r_rr     <= '0;
    end else if (w_b_hs) begin
      r_locked <= 1'b0;
      r_rr     <= (w_grant == SRC_W'(NUM_SLAVES)) ? '0 : w_grant + SRC_W'(1);
    end else if (m_bvalid) begin
      r_locked <= 1'b1;
      r_grant  <= w_grant;
    end
  end

endmodule

// File: tb/tb_axi4_wr_route_checker.sv
// Directed bench for axi4_wr_route_checker: routing, error draining, FIFO
// back-pressure and B arbitration, with a scoreboard of expected B responses.
module tb_axi4_wr_route_checker;

  logic        aclk, areset;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize, m_awprot;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [51:0] s_aw;
  logic [2:0]  s_awvalid, s_awready;
  logic [72:0] s_w;
  logic [2:0]  s_wvalid, s_wready;
  logic [11:0] s_bid;
  logic [5:0]  s_bresp;
  logic [2:0]  s_bvalid, s_bready;
  logic [15:0] decerr_cnt, slverr_cnt;
  logic        wlast_err;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  b_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_dec  = 0;
  int exp_slv  = 0;

  axi4_wr_route_checker #(
    .SLV_SECURE_ONLY (3'b001),
    .SLV_PRIV_ONLY   (3'b100),
    .ROUTE_DEPTH     (2)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .m_awid     (m_awid),
    .m_awaddr   (m_awaddr),
    .m_awlen    (m_awlen),
    .m_awsize   (m_awsize),
    .m_awburst  (m_awburst),
    .m_awprot   (m_awprot),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wlast    (m_wlast),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bid      (m_bid),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .s_aw       (s_aw),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_w        (s_w),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bid      (s_bid),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .decerr_cnt (decerr_cnt),
    .slverr_cnt (slverr_cnt),
    .wlast_err  (wlast_err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected B and compare against the DUT's current B
  task automatic check_b();
    b_exp_t e;
    logic   have;
    have = (sb.size() != 0);
    chk("sb_nonempty", {127'd0, have}, 128'd1);
    if (have) begin
      e = sb.pop_front();
      chk("b_id", {124'd0, m_bid}, {124'd0, e.id});
      chk("b_resp", {126'd0, m_bresp}, {126'd0, e.resp});
    end
  endtask

  // All tasks start and end at a falling edge; the DUT samples at the rising edge between
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                         input logic [2:0] exp_sv, input logic [1:0] exp_resp);
    m_awid = id; m_awaddr = addr; m_awlen = len; m_awsize = size;
    m_awburst = burst; m_awprot = prot; m_awvalid = 1'b1;
    #1;
    chk("aw_ready", {127'd0, m_awready}, 128'd1);
    chk("s_awvalid", {125'd0, s_awvalid}, {125'd0, exp_sv});
    chk("s_aw", {76'd0, s_aw}, {76'd0, id, addr, len, size, burst, prot});
    if (exp_sv == 3'b000) begin
      sb.push_back('{id: id, resp: exp_resp});
      if (exp_resp == 2'b11) exp_dec++;
      else exp_slv++;
    end
    @(negedge aclk);
    m_awvalid = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [2:0] exp_sv);
    for (int b = 0; b < n; b++) begin
      logic got;
      got = 1'b0;
      m_wdata  = {$urandom, $urandom};
      m_wstrb  = 8'hFF;
      m_wlast  = (b == n - 1);
      m_wvalid = 1'b1;
      for (int c = 0; c < 10 && !got; c++) begin
        #1;
        if (m_wready) begin
          got = 1'b1;
          chk("s_wvalid", {125'd0, s_wvalid}, {125'd0, exp_sv});
          chk("s_w", {55'd0, s_w}, {55'd0, m_wdata, m_wstrb, m_wlast});
        end
        @(negedge aclk);
      end
      chk("w_accept", {127'd0, got}, 128'd1);
    end
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
  endtask

  task automatic wait_b();
    logic got;
    got = 1'b0;
    m_bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (m_bvalid) begin
        got = 1'b1;
        check_b();
      end
      @(negedge aclk);
    end
    chk("b_seen", {127'd0, got}, 128'd1);
    m_bready = 1'b0;
  endtask

  task automatic chk_cnts();
    chk("decerr_cnt", {112'd0, decerr_cnt}, 128'(exp_dec));
    chk("slverr_cnt", {112'd0, slverr_cnt}, 128'(exp_slv));
  endtask

  initial begin
    areset = 1'b1;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = 2'b01;
    m_awprot = '0; m_awvalid = 1'b1;
    m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b1; m_bready = 1'b1;
    s_awready = 3'b111; s_wready = 3'b111; s_bid = '0; s_bresp = '0; s_bvalid = 3'b111;
    @(negedge aclk);
    @(negedge aclk);
    // Outputs gated during reset even with every input active
    #1;
    chk("rst_awready", {127'd0, m_awready}, 128'd0);
    chk("rst_awvalid", {125'd0, s_awvalid}, 128'd0);
    chk("rst_wready", {127'd0, m_wready}, 128'd0);
    chk("rst_bvalid", {127'd0, m_bvalid}, 128'd0);
    chk("rst_bready", {125'd0, s_bready}, 128'd0);
    @(negedge aclk);
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0; s_bvalid = 3'b000;
    areset = 1'b0;
    #1;
    chk("idle_wready", {127'd0, m_wready}, 128'd0);
    chk("idle_bvalid", {127'd0, m_bvalid}, 128'd0);
    chk("idle_wlast_err", {127'd0, wlast_err}, 128'd0);
    chk_cnts();
    @(negedge aclk);

    // 1: good INCR to slave 1, slave B OKAY forwarded
    send_aw(4'd5, 32'h1000_0040, 8'd3, 3'd3, 2'b01, 3'b000, 3'b010, 2'b00);
    send_w(4, 3'b010);
    s_bvalid = 3'b010; s_bid[7:4] = 4'd5; s_bresp[3:2] = 2'b00;
    sb.push_back('{id: 4'd5, resp: 2'b00});
    #1;
    chk("s_bready_s1", {125'd0, s_bready}, 128'd0);
    @(negedge aclk);
    wait_b();
    s_bvalid = 3'b000;

    // 2: decode miss, drained and answered with DECERR
    send_aw(4'd2, 32'h7000_0000, 8'd1, 3'd3, 2'b01, 3'b000, 3'b000, 2'b11);
    send_w(2, 3'b000);
    wait_b();
    chk_cnts();

    // 3: INCR crossing 4KB rejected, FIXED of the same shape forwarded
    send_aw(4'd3, 32'h1000_0FF8, 8'd1, 3'd3, 2'b01, 3'b000, 3'b000, 2'b10);
    send_w(2, 3'b000);
    wait_b();
    chk_cnts();
    send_aw(4'd4, 32'h1000_0FF8, 8'd1, 3'd3, 2'b00, 3'b000, 3'b010, 2'b00);
    send_w(2, 3'b010);

    // 4: protection, oversize and WLAST position
    send_aw(4'd6, 32'h0000_0100, 8'd0, 3'd3, 2'b01, 3'b010, 3'b000, 2'b10);
    send_w(1, 3'b000);
    wait_b();
    send_aw(4'd12, 32'h0000_0100, 8'd0, 3'd3, 2'b01, 3'b000, 3'b001, 2'b00);
    send_w(1, 3'b001);
    s_bvalid = 3'b001; s_bid[3:0] = 4'd12; s_bresp[1:0] = 2'b00;
    sb.push_back('{id: 4'd12, resp: 2'b00});
    wait_b();
    s_bvalid = 3'b000;
    send_aw(4'd13, 32'h1000_0000, 8'd0, 3'd4, 2'b01, 3'b000, 3'b000, 2'b10);
    send_w(1, 3'b000);
    wait_b();
    send_aw(4'd14, 32'h2000_0000, 8'd0, 3'd3, 2'b01, 3'b000, 3'b000, 2'b10);
    send_w(1, 3'b000);
    wait_b();
    chk("wlast_err_clear", {127'd0, wlast_err}, 128'd0);
    send_aw(4'd7, 32'h7000_0000, 8'd1, 3'd3, 2'b01, 3'b000, 3'b000, 2'b11);
    send_w(1, 3'b000);
    wait_b();
    chk("wlast_err_set", {127'd0, wlast_err}, 128'd1);
    chk_cnts();

    // 5: two-entry route FIFO fills while slaves stall W
    s_wready = 3'b000;
    send_aw(4'd8, 32'h1000_0000, 8'd0, 3'd3, 2'b01, 3'b000, 3'b010, 2'b00);
    send_aw(4'd9, 32'h1000_0010, 8'd0, 3'd3, 2'b01, 3'b000, 3'b010, 2'b00);
    m_awid = 4'd1; m_awaddr = 32'h1000_0100; m_awlen = 8'd0; m_awvalid = 1'b1;
    #1;
    chk("full_awready", {127'd0, m_awready}, 128'd0);
    chk("full_awvalid", {125'd0, s_awvalid}, 128'd0);
    chk("stall_wready", {127'd0, m_wready}, 128'd0);
    s_wready = 3'b010; m_wvalid = 1'b1; m_wlast = 1'b1;
    #1;
    chk("pop_wready", {127'd0, m_wready}, 128'd1);
    chk("pop_awready", {127'd0, m_awready}, 128'd0);
    @(negedge aclk);
    m_wvalid = 1'b0; m_wlast = 1'b0;
    #1;
    chk("after_pop_awready", {127'd0, m_awready}, 128'd1);
    chk("after_pop_awvalid", {125'd0, s_awvalid}, 128'd2);
    @(negedge aclk);
    m_awvalid = 1'b0;
    s_wready = 3'b111;
    send_w(1, 3'b010);
    send_w(1, 3'b010);

    // 6: slaves 0, 1 and the responder contend for B
    s_bvalid = 3'b011; s_bid[3:0] = 4'd11; s_bresp[1:0] = 2'b00;
    s_bid[7:4] = 4'd13; s_bresp[3:2] = 2'b01;
    sb.push_back('{id: 4'd11, resp: 2'b00});
    sb.push_back('{id: 4'd13, resp: 2'b01});
    send_aw(4'd10, 32'h7000_0000, 8'd0, 3'd3, 2'b01, 3'b000, 3'b000, 2'b11);
    send_w(1, 3'b000);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_bvalid", {127'd0, m_bvalid}, 128'd1);
      chk("hold_bid", {124'd0, m_bid}, 128'd11);
      chk("hold_sbready", {125'd0, s_bready}, 128'd0);
      @(negedge aclk);
    end
    m_bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] exp_rdy;
      exp_rdy = (k == 2) ? 3'b000 : 3'(1 << k);
      #1;
      chk("rr_bvalid", {127'd0, m_bvalid}, 128'd1);
      chk("rr_sbready", {125'd0, s_bready}, {125'd0, exp_rdy});
      check_b();
      @(negedge aclk);
      if (k < 2) s_bvalid[k] = 1'b0;
    end
    m_bready = 1'b0;
    #1;
    chk("rr_drained", {127'd0, m_bvalid}, 128'd0);
    chk_cnts();
    chk("sb_empty", 128'(sb.size()), 128'd0);
    @(negedge aclk);

    // Reset mid-burst abandons the in-flight write
    send_aw(4'd3, 32'h1000_0000, 8'd3, 3'd3, 2'b01, 3'b000, 3'b010, 2'b00);
    areset = 1'b1;
    #1;
    chk("midrst_wready", {127'd0, m_wready}, 128'd0);
    @(negedge aclk);
    areset = 1'b0;
    m_wvalid = 1'b1;
    #1;
    chk("postrst_wready", {127'd0, m_wready}, 128'd0);
    chk("postrst_wlast_err", {127'd0, wlast_err}, 128'd0);
    chk("postrst_decerr", {112'd0, decerr_cnt}, 128'd0);
    chk("postrst_slverr", {112'd0, slverr_cnt}, 128'd0);
    m_wvalid = 1'b0;
    @(negedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
